// File: rtl/specinvert_core.sv
// Spectral-inversion user logic for the specinvert RFNoC block: per-packet conjugate
// and/or fs/2 shift of an sc16 stream, with a small CtrlPort register file.
module specinvert_core #(
  parameter int          ITEM_W = 32,
  parameter logic [31:0] COMPAT = 32'h0001_0000
) (
  input  logic              ce_clk,
  input  logic              ce_rst,
  input  logic              s_ctrlport_req_wr,
  input  logic              s_ctrlport_req_rd,
  input  logic [19:0]       s_ctrlport_req_addr,
  input  logic [31:0]       s_ctrlport_req_data,
  output logic              s_ctrlport_resp_ack,
  output logic [31:0]       s_ctrlport_resp_data,
  input  logic [ITEM_W-1:0] s_in_axis_tdata,
  input  logic              s_in_axis_tkeep,
  input  logic              s_in_axis_tlast,
  input  logic              s_in_axis_tvalid,
  output logic              s_in_axis_tready,
  input  logic [63:0]       s_in_axis_ttimestamp,
  input  logic              s_in_axis_thas_time,
  input  logic [15:0]       s_in_axis_tlength,
  input  logic              s_in_axis_teov,
  input  logic              s_in_axis_teob,
  output logic [ITEM_W-1:0] m_out_axis_tdata,
  output logic              m_out_axis_tkeep,
  output logic              m_out_axis_tlast,
  output logic              m_out_axis_tvalid,
  input  logic              m_out_axis_tready,
  output logic [63:0]       m_out_axis_ttimestamp,
  output logic              m_out_axis_thas_time,
  output logic [15:0]       m_out_axis_tlength,
  output logic              m_out_axis_teov,
  output logic              m_out_axis_teob
);

  localparam logic [19:0] REG_MODE       = 20'h00;
  localparam logic [19:0] REG_PHASE_RST  = 20'h04;
  localparam logic [19:0] REG_SAMPLE_CNT = 20'h08;
  localparam logic [19:0] REG_COMPAT     = 20'h0C;

  logic [1:0]  reg_mode;
  logic [1:0]  active_mode;
  logic        first;
  logic        phase;
  logic [31:0] sample_cnt;

  logic        accept;
  logic        phase_clr;
  logic [1:0]  eff_mode;
  logic        negate;
  logic [15:0] i_in, q_in, q_conj, i_out, q_out;
  logic        unused_data_bits;

  // Saturating negation: -32768 has no positive counterpart, so it clips to 32767.
  function automatic logic [15:0] sat_neg(input logic [15:0] x);
    return (x == 16'h8000) ? 16'h7FFF : (~x + 16'd1);
  endfunction

  assign s_in_axis_tready = !m_out_axis_tvalid || m_out_axis_tready;
  assign accept           = s_in_axis_tvalid && s_in_axis_tready;
  assign phase_clr        = s_ctrlport_req_wr && (s_ctrlport_req_addr == REG_PHASE_RST)
                            && s_ctrlport_req_data[0];
  assign unused_data_bits = ^s_ctrlport_req_data[31:2];

  // The first sample of a packet sees REG_MODE directly, since active_mode loads on that same edge.
  assign eff_mode = first ? reg_mode : active_mode;
  assign negate   = eff_mode[1] && phase;
  assign i_in     = s_in_axis_tdata[31:16];
  assign q_in     = s_in_axis_tdata[15:0];
  assign q_conj   = eff_mode[0] ? sat_neg(q_in) : q_in;
  assign i_out    = negate ? sat_neg(i_in) : i_in;
  assign q_out    = negate ? sat_neg(q_conj) : q_conj;

  // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge ce_clk) begin
    if (ce_rst) begin
      s_ctrlport_resp_ack  <= 1'b0;
      s_ctrlport_resp_data <= '0;
      reg_mode             <= '0;
    end else begin
      s_ctrlport_resp_ack  <= s_ctrlport_req_wr || s_ctrlport_req_rd;
      s_ctrlport_resp_data <= '0;
      if (s_ctrlport_req_rd) begin
        case (s_ctrlport_req_addr)
          REG_MODE:       s_ctrlport_resp_data <= {30'd0, reg_mode};
          REG_SAMPLE_CNT: s_ctrlport_resp_data <= sample_cnt;
          REG_COMPAT:     s_ctrlport_resp_data <= COMPAT;
          default:        s_ctrlport_resp_data <= '0;
        endcase
      end
      if (s_ctrlport_req_wr && (s_ctrlport_req_addr == REG_MODE))
        reg_mode <= s_ctrlport_req_data[1:0];
    end
  end

  always_ff @(posedge ce_clk) begin
    if (ce_rst) begin
      active_mode <= '0;
      first       <= 1'b1;
      phase       <= 1'b0;
    end else begin
      if (accept) begin
        if (first) active_mode <= reg_mode;
        first <= s_in_axis_tlast;
      end
      if (phase_clr)
        phase <= 1'b0;
      else if (accept)
        phase <= (s_in_axis_tlast && s_in_axis_teob) ? 1'b0 : !phase;
    end
  end

  // NOTE: the data/sideband registers are reset as well, because the output bus must read zero after reset.
  always_ff @(posedge ce_clk) begin
    if (ce_rst) begin
      m_out_axis_tvalid     <= 1'b0;
      m_out_axis_tdata      <= '0;
      m_out_axis_tkeep      <= 1'b0;
      m_out_axis_tlast      <= 1'b0;
      m_out_axis_ttimestamp <= '0;
      m_out_axis_thas_time  <= 1'b0;
      m_out_axis_tlength    <= '0;
      m_out_axis_teov       <= 1'b0;
      m_out_axis_teob       <= 1'b0;
      sample_cnt            <= '0;
    end else begin
      if (s_in_axis_tready) begin
        m_out_axis_tvalid <= s_in_axis_tvalid;
        if (s_in_axis_tvalid) begin
          m_out_axis_tdata      <= {i_out, q_out};
          m_out_axis_tkeep      <= s_in_axis_tkeep;
          m_out_axis_tlast      <= s_in_axis_tlast;
          m_out_axis_ttimestamp <= s_in_axis_ttimestamp;
          m_out_axis_thas_time  <= s_in_axis_thas_time;
          m_out_axis_tlength    <= s_in_axis_tlength;
          m_out_axis_teov       <= s_in_axis_teov;
          m_out_axis_teob       <= s_in_axis_teob;
        end
      end
      if (m_out_axis_tvalid && m_out_axis_tready)
        sample_cnt <= sample_cnt + 32'd1;
    end
  end

endmodule
